// File: rtl/bus_slave_response_collector_pkg.sv
// bus_slave_response_collector_pkg: shared bus config, state encoding and response kinds
package bus_slave_response_collector_pkg;
    localparam int BUS_SLAVE_NUMBER = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
    typedef enum logic {
        RESP_ACK = 1'b0,
        RESP_ERR = 1'b1
    } resp_kind_t;
endpackage

// File: rtl/bus_slave_response_collector_watchdog.sv
// bus_watchdog_counter: saturating wait-cycle counter flagging when TIMEOUT is reached
module bus_watchdog_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    assign expired_o = cnt == CW'(TIMEOUT);
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) cnt <= '0;
        else if (en_i && !expired_o) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/bus_slave_response_collector.sv
// bus_slave_response_collector: muxes selected slave ack/err/data back to the master with watchdog
module bus_slave_response_collector
    import bus_slave_response_collector_pkg::*;
#(
    parameter int SLAVE_NUMBER = BUS_SLAVE_NUMBER,
    parameter int DATA_WIDTH   = 32,
    parameter int TIMEOUT      = 255
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             stb_i,
    input  logic                             cyc_i,
    input  logic [SLAVE_NUMBER-1:0]          cs_i,
    input  logic                             adr_err_i,
    input  logic [SLAVE_NUMBER-1:0]          s_ack_i,
    input  logic [SLAVE_NUMBER-1:0]          s_err_i,
    input  logic [SLAVE_NUMBER*DATA_WIDTH-1:0] s_dat_i,
    output logic                             ack_o,
    output logic                             err_o,
    output logic [DATA_WIDTH-1:0]            dat_o,
    output logic                             timeout_o,
    output logic                             busy_o
);
    localparam int SW = SLAVE_NUMBER > 1 ? $clog2(SLAVE_NUMBER) : 1;

    function automatic logic [SW-1:0] lowest(input logic [SLAVE_NUMBER-1:0] v);
        lowest = '0;
        for (int i = SLAVE_NUMBER - 1; i >= 0; i--)
            if (v[i]) lowest = SW'(i);
    endfunction

    state_t        state;
    logic [SW-1:0] sel;
    logic          expired;
    logic          req;
    logic          done;
    resp_kind_t    kind;

    assign req    = stb_i & cyc_i;
    assign busy_o = state != IDLE;

    always_comb begin
        done = s_err_i[sel] | s_ack_i[sel] | expired;
        kind = (s_err_i[sel] | ~s_ack_i[sel]) ? RESP_ERR : RESP_ACK;
    end

    bus_watchdog_counter #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (state != WAIT),
        .en_i     (state == WAIT),
        .expired_o(expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            sel       <= '0;
            ack_o     <= 1'b0;
            err_o     <= 1'b0;
            dat_o     <= '0;
            timeout_o <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    if (adr_err_i || cs_i == '0) begin
                        err_o <= 1'b1;
                        state <= RESP;
                    end else begin
                        sel   <= lowest(cs_i);
                        state <= WAIT;
                    end
                end
                WAIT: if (!req) state <= IDLE;
                else if (done) begin
                    state <= RESP;
                    ack_o <= kind == RESP_ACK;
                    err_o <= kind == RESP_ERR;
                    if (kind == RESP_ACK) dat_o <= s_dat_i[sel*DATA_WIDTH +: DATA_WIDTH];
                    if (!s_err_i[sel] && !s_ack_i[sel]) timeout_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_slave_response_collector.sv
// tb_bus_slave_response_collector: vector table, corner sequences and randomized model check
module tb_bus_slave_response_collector;
    localparam int N  = 8;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk_i = 1'b0;
    logic          rst_i, stb_i, cyc_i, adr_err_i;
    logic [N-1:0]  cs_i, s_ack_i, s_err_i;
    logic [N*DW-1:0] s_dat_i;
    logic          ack_o, err_o, timeout_o, busy_o;
    logic [DW-1:0] dat_o;

    int checks = 0;
    int errors = 0;

    bus_slave_response_collector #(.SLAVE_NUMBER(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stb_i(stb_i), .cyc_i(cyc_i), .cs_i(cs_i),
        .adr_err_i(adr_err_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_dat_i(s_dat_i),
        .ack_o(ack_o), .err_o(err_o), .dat_o(dat_o), .timeout_o(timeout_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit         rst, stb, cyc, ae;
        bit [7:0]   cs, ack, err;
        bit         e_ack, e_err, e_busy;
        bit [31:0]  e_dat;
    } vec_t;
    vec_t tq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit r, input bit s, input bit c, input bit [7:0] cs,
                          input bit ae, input bit [7:0] a, input bit [7:0] e);
        rst_i = r; stb_i = s; cyc_i = c; cs_i = cs; adr_err_i = ae; s_ack_i = a; s_err_i = e;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic add(input bit r, input bit s, input bit c, input bit [7:0] cs, input bit ae,
                       input bit [7:0] a, input bit [7:0] e, input bit ea, input bit ee,
                       input bit eb, input bit [31:0] ed);
        vec_t v;
        v.rst = r; v.stb = s; v.cyc = c; v.cs = cs; v.ae = ae; v.ack = a; v.err = e;
        v.e_ack = ea; v.e_err = ee; v.e_busy = eb; v.e_dat = ed;
        tq.push_back(v);
    endtask

    // Behavioural reference: one outstanding transaction, its age, and a pending response slot.
    bit        m_flight, m_resp, m_ack, m_err, m_to;
    int        m_age, m_sel;
    bit [31:0] m_dat;

    task automatic model_step();
        bit r;
        r = stb_i && cyc_i;
        m_ack = 0; m_err = 0;
        if (rst_i) begin
            m_flight = 0; m_resp = 0; m_to = 0; m_dat = 0;
        end else if (m_resp) begin
            m_resp = 0;
        end else if (!m_flight) begin
            if (r) begin
                if (adr_err_i || cs_i == 0) begin
                    m_err = 1; m_resp = 1;
                end else begin
                    for (int i = 0; i < N; i++) if (cs_i[i]) begin m_sel = i; break; end
                    m_flight = 1; m_age = 0;
                end
            end
        end else if (!r) begin
            m_flight = 0;
        end else if (s_err_i[m_sel]) begin
            m_err = 1; m_flight = 0; m_resp = 1;
        end else if (s_ack_i[m_sel]) begin
            m_ack = 1; m_dat = s_dat_i[m_sel*DW +: DW]; m_flight = 0; m_resp = 1;
        end else if (m_age == TO) begin
            m_err = 1; m_to = 1; m_flight = 0; m_resp = 1;
        end else begin
            m_age++;
        end
    endtask

    initial begin
        int n;
        bit found;
        for (int k = 0; k < N; k++) s_dat_i[k*DW +: DW] = 32'hC0DE_0000 | k;
        s_dat_i[2*DW +: DW] = 32'hDEADBEEF;
        set_in(0, 0, 0, 0, 0, 0, 0);

        add(1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 32'h0);
        add(0, 1, 1, 8'h04, 0, 8'h00, 8'h00, 0, 0, 1, 32'h0);
        add(0, 1, 1, 8'h04, 0, 8'h00, 8'h00, 0, 0, 1, 32'h0);
        add(0, 1, 1, 8'h04, 0, 8'h00, 8'h00, 0, 0, 1, 32'h0);
        add(0, 1, 1, 8'h04, 0, 8'h00, 8'h00, 0, 0, 1, 32'h0);
        add(0, 1, 1, 8'h04, 0, 8'h04, 8'h00, 1, 0, 1, 32'hDEADBEEF);
        add(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 32'hDEADBEEF);
        add(0, 1, 1, 8'h00, 1, 8'h00, 8'h00, 0, 1, 1, 32'hDEADBEEF);
        add(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 32'hDEADBEEF);
        add(0, 1, 1, 8'h02, 0, 8'h00, 8'h00, 0, 0, 1, 32'hDEADBEEF);
        add(0, 1, 1, 8'h02, 0, 8'h02, 8'h02, 0, 1, 1, 32'hDEADBEEF);
        add(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 32'hDEADBEEF);
        add(0, 1, 1, 8'h0A, 0, 8'h00, 8'h00, 0, 0, 1, 32'hDEADBEEF);
        add(0, 1, 1, 8'h0A, 0, 8'h08, 8'h08, 0, 0, 1, 32'hDEADBEEF);
        add(0, 1, 1, 8'h0A, 0, 8'h02, 8'h00, 1, 0, 1, 32'hC0DE0001);
        add(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 32'hC0DE0001);
        add(0, 1, 1, 8'h01, 0, 8'h00, 8'h00, 0, 0, 1, 32'hC0DE0001);
        add(0, 0, 1, 8'h01, 0, 8'h01, 8'h00, 0, 0, 0, 32'hC0DE0001);
        add(0, 1, 1, 8'h00, 0, 8'h00, 8'h00, 0, 1, 1, 32'hC0DE0001);
        add(0, 1, 1, 8'h04, 0, 8'h00, 8'h00, 0, 0, 0, 32'hC0DE0001);
        add(0, 1, 1, 8'h04, 0, 8'h00, 8'h00, 0, 0, 1, 32'hC0DE0001);
        add(0, 1, 0, 8'h04, 0, 8'h04, 8'h00, 0, 0, 0, 32'hC0DE0001);

        foreach (tq[i]) begin
            set_in(tq[i].rst, tq[i].stb, tq[i].cyc, tq[i].cs, tq[i].ae, tq[i].ack, tq[i].err);
            step();
            chk($sformatf("vec%0d_ack", i), 32'(ack_o), 32'(tq[i].e_ack));
            chk($sformatf("vec%0d_err", i), 32'(err_o), 32'(tq[i].e_err));
            chk($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(tq[i].e_busy));
            chk($sformatf("vec%0d_dat", i), dat_o, tq[i].e_dat);
            chk($sformatf("vec%0d_timeout", i), 32'(timeout_o), 32'h0);
        end

        set_in(0, 1, 1, 8'h20, 0, 0, 0);
        step();
        n = 0; found = 0;
        while (!found && n < 20) begin
            step();
            n++;
            if (err_o || ack_o) found = 1;
        end
        chk("timeout_latency_edges", n, TO + 1);
        chk("timeout_err", 32'(err_o), 32'h1);
        chk("timeout_flag", 32'(timeout_o), 32'h1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("timeout_err_one_cycle", 32'(err_o), 32'h0);
        set_in(0, 1, 1, 8'h01, 0, 8'h01, 0);
        step();
        step();
        chk("after_to_ack", 32'(ack_o), 32'h1);
        chk("after_to_dat", dat_o, 32'hC0DE0000);
        chk("timeout_sticky", 32'(timeout_o), 32'h1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        step();
        set_in(0, 1, 1, 8'h04, 0, 0, 0);
        step();
        chk("pre_reset_busy", 32'(busy_o), 32'h1);
        set_in(1, 1, 1, 8'h04, 0, 8'h04, 0);
        step();
        chk("mid_reset_ack", 32'(ack_o), 32'h0);
        chk("mid_reset_err", 32'(err_o), 32'h0);
        chk("mid_reset_busy", 32'(busy_o), 32'h0);
        chk("mid_reset_timeout", 32'(timeout_o), 32'h0);
        chk("mid_reset_dat", dat_o, 32'h0);
        set_in(0, 1, 1, 8'h04, 0, 8'h04, 0);
        step();
        step();
        chk("post_reset_ack", 32'(ack_o), 32'h1);
        chk("post_reset_dat", dat_o, 32'hDEADBEEF);

        set_in(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk_i);
        model_step();
        #1;
        for (int c = 0; c < 600; c++) begin
            bit s;
            s = $urandom_range(0, 9) != 0;
            rst_i     = $urandom_range(0, 99) == 0;
            stb_i     = s;
            cyc_i     = s || ($urandom_range(0, 1) == 0);
            cs_i      = $urandom_range(0, 9) == 0 ? 8'($urandom) :
                        ($urandom_range(0, 19) == 0 ? 8'h00 : 8'(1) << $urandom_range(0, N - 1));
            adr_err_i = $urandom_range(0, 19) == 0;
            s_ack_i   = 8'($urandom & $urandom & $urandom);
            s_err_i   = 8'($urandom & $urandom & $urandom & $urandom);
            for (int k = 0; k < N; k++) s_dat_i[k*DW +: DW] = $urandom;
            @(posedge clk_i);
            model_step();
            #1;
            chk("rand_ack", 32'(ack_o), 32'(m_ack));
            chk("rand_err", 32'(err_o), 32'(m_err));
            chk("rand_busy", 32'(busy_o), 32'(m_flight || m_resp));
            chk("rand_timeout", 32'(timeout_o), 32'(m_to));
            chk("rand_dat", dat_o, m_dat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_slave_response_collector.md
Name: bus_slave_response_collector

Overview:
- Return-path companion to the bus address decoder.
- Takes the one-hot slave select and address-error flag produced on the request path, and tracks the outstanding transfer.
- Muxes the selected slave's ack/err/read data back to the single master as registered one-cycle responses.
- Converts address errors and unresponsive slaves (watchdog timeout) into a master-visible err_o, so the CPU bus never hangs.

Parameters:
- SLAVE_NUMBER, 8, number of slave ports; must equal the decoder's slave count.
- DATA_WIDTH, 32, read data width per slave.
- TIMEOUT, 255, maximum WAIT cycles before a forced error; range 1..65535.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- stb_i  in  1  master strobe (request valid).
- cyc_i  in  1  master cycle-in-progress.
- cs_i  in  SLAVE_NUMBER  one-hot slave select from the decoder (already gated by stb).
- adr_err_i  in  1  no-slave-matched flag from the decoder.
- s_ack_i  in  SLAVE_NUMBER  per-slave ack.
- s_err_i  in  SLAVE_NUMBER  per-slave err.
- s_dat_i  in  SLAVE_NUMBER*DATA_WIDTH  per-slave read data; slave k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- ack_o  out  1  one-cycle ack to the master.
- err_o  out  1  one-cycle err to the master.
- dat_o  out  DATA_WIDTH  registered read data; valid while ack_o is high.
- timeout_o  out  1  sticky flag: a watchdog timeout has occurred.
- busy_o  out  1  high while state != IDLE.

Behaviour:
- Reset (synchronous, rst_i=1): state=IDLE, counter=0, sel=0. Outputs ack_o=0, err_o=0, dat_o=0, timeout_o=0, busy_o=0. Reset mid-transfer abandons the transfer silently; no response is issued.
- State IDLE:
  - On stb_i&cyc_i with adr_err_i=1: go to RESP with err pending.
  - On stb_i&cyc_i with a nonzero cs_i: latch sel = index of lowest set bit of cs_i (multi-hot resolves to the lowest index), clear counter, go to WAIT.
  - stb_i&cyc_i with cs_i=0 and adr_err_i=0: treat as an address error.
- State WAIT:
  - Any cycle with stb_i=0 or cyc_i=0 is a master abort: go to IDLE, no response.
  - If s_err_i[sel]: go to RESP with err pending.
  - Else if s_ack_i[sel]: capture s_dat_i slice sel into dat_o, go to RESP with ack pending.
  - Else if counter==TIMEOUT: go to RESP with err pending, set timeout_o.
  - Otherwise counter+1. Counter width is $clog2(TIMEOUT+1) and never wraps.
  - The check is evaluated in the first WAIT cycle, so a slave acking in that cycle is accepted.
- State RESP (exactly 1 cycle): assert the pending ack_o or err_o (never both), then go to IDLE.
  - stb_i is ignored in this cycle; the master must drop stb_i or present a new request, which is sampled in IDLE on the next cycle.
- Latency: slave ack at cycle t produces ack_o at t+1. Address error at request cycle t produces err_o at t+1. Timeout produces err_o TIMEOUT+2 cycles after request acceptance.
- Simultaneous s_ack_i[sel] and s_err_i[sel]: err wins; dat_o is not updated.
- s_ack_i and s_err_i from non-selected slaves are ignored in all states.
- dat_o holds its last captured value between acks; it changes only on an accepted ack.
- timeout_o stays set until rst_i.
- busy_o = (state != IDLE), combinational from the state register.

Decomposition:
- Shared package/include holds:
  - SLAVE_NUMBER, kept in the existing BusConfig include as the single source of truth;
  - state encoding constants IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - response-kind constants for ack and err.
- One natural sub-module: bus_watchdog_counter, parameter TIMEOUT, with ports clk_i, rst_i, clr_i, en_i, expired_o.
- The priority encoder for lowest-set-bit stays inline as a function.

Test Plan:
- Normal read: cs_i=8'h04; slave 2 acks 3 cycles later with data 32'hDEADBEEF -> ack_o one cycle later, dat_o=32'hDEADBEEF, err_o=0, busy_o high for 5 cycles total.
- Address error: stb_i=cyc_i=1, adr_err_i=1 -> err_o=1 for exactly one cycle at t+1, ack_o=0, timeout_o=0.
- Timeout with TIMEOUT=4: select slave 5, which never responds -> err_o asserted 6 cycles after acceptance; timeout_o=1 and stays 1 across the next successful transfer until rst_i.
- Ack and err together: slave 1 asserts s_ack_i[1] and s_err_i[1] in the same cycle -> err_o=1, ack_o=0, dat_o unchanged.
- Unselected and multi-hot handling: cs_i=8'h0A selects slave 1; s_ack_i[3] pulses and is ignored, then s_ack_i[1] -> ack_o with slave 1 data.
- Abort and reset: stb_i drops in WAIT -> no ack_o/err_o, back to IDLE. Separately, rst_i asserted during WAIT -> all outputs 0 next cycle, and a following request completes normally.
